// File: rtl/resource_arb_pkg.sv
// Shared types and default parameters for the resource arbiter slice.
package resource_arb_pkg;

  localparam int NUM_REQ_DEF   = 4;
  localparam int DATA_W_DEF    = 32;
  localparam int RES_LAT_DEF   = 2;
  localparam int MAX_BURST_DEF = 4;

  // Wide enough for the largest supported requestor count (8).
  localparam int IDX_W = 3;

  typedef logic [IDX_W-1:0] idx_t;

  typedef struct packed {
    logic valid;
    idx_t index;
  } tag_t;

  typedef enum logic {
    IDLE,
    OWN
  } arb_state_t;

endpackage

// File: rtl/resource_arbiter_if.sv
// Requestor/resource bus of the arbiter; slave is the arbiter, master the pipelines and resource.
interface resource_arbiter_if #(
  parameter int NUM_REQ = resource_arb_pkg::NUM_REQ_DEF,
  parameter int DATA_W  = resource_arb_pkg::DATA_W_DEF
);

  logic [NUM_REQ-1:0]        req;
  logic [NUM_REQ*DATA_W-1:0] req_data;
  logic [NUM_REQ-1:0]        grant;
  logic                      res_in_valid;
  logic [DATA_W-1:0]         res_in_data;
  logic [DATA_W-1:0]         res_out_data;
  logic [NUM_REQ-1:0]        rsp_valid;
  logic [DATA_W-1:0]         rsp_data;

  modport master (
    output req, req_data, res_out_data,
    input  grant, res_in_valid, res_in_data, rsp_valid, rsp_data
  );

  modport slave (
    input  req, req_data, res_out_data,
    output grant, res_in_valid, res_in_data, rsp_valid, rsp_data
  );

endinterface

// File: rtl/resource_arbiter_rr_pick.sv
// Round-robin picker: first requestor with req high, searching from last_owner+1 and wrapping.
module rr_pick
  import resource_arb_pkg::*;
#(
  parameter int NUM_REQ = NUM_REQ_DEF
) (
  input  logic [NUM_REQ-1:0] req,
  input  idx_t               last_owner,
  output logic               found,
  output idx_t               index
);

  // Walk from the farthest candidate back to the nearest so the nearest one wins;
  // the last candidate is last_owner itself, letting a lone requestor be re-picked.
  always_comb begin
    found = 1'b0;
    index = '0;
    for (int k = NUM_REQ; k >= 1; k--) begin
      if (req[(int'(last_owner) + k) % NUM_REQ]) begin
        found = 1'b1;
        index = idx_t'((int'(last_owner) + k) % NUM_REQ);
      end
    end
  end

endmodule

// File: rtl/resource_arbiter.sv
// Shares one fixed-latency resource among NUM_REQ pipelines with bounded round-robin bursts
// and routes each result back to its issuer through a tag pipeline.
module resource_arbiter
  import resource_arb_pkg::*;
#(
  parameter int NUM_REQ   = NUM_REQ_DEF,
  parameter int DATA_W    = DATA_W_DEF,
  parameter int RES_LAT   = RES_LAT_DEF,
  parameter int MAX_BURST = MAX_BURST_DEF
) (
  input  logic               clk,
  input  logic               reset,
  resource_arbiter_if.slave  bus
);

  localparam int CNT_W = (MAX_BURST > 1) ? $clog2(MAX_BURST) : 1;

  arb_state_t        r_state;
  logic [NUM_REQ-1:0] r_grant;
  idx_t              r_owner;
  idx_t              r_last_owner;
  logic [CNT_W-1:0]  r_burst_cnt;
  tag_t              r_tag [RES_LAT];

  logic              w_transfer;
  logic              w_keep;
  logic              w_found;
  idx_t              w_pick;
  logic [DATA_W-1:0] w_in_data;
  tag_t              w_head;

  rr_pick #(
    .NUM_REQ (NUM_REQ)
  ) u_rr_pick (
    .req        (bus.req),
    .last_owner (r_last_owner),
    .found      (w_found),
    .index      (w_pick)
  );

  assign w_transfer = |(r_grant & bus.req);
  assign w_keep     = (r_state == OWN) && w_transfer && (int'(r_burst_cnt) < MAX_BURST - 1);

  // Owner keeps the grant while requesting and under its burst limit; otherwise round-robin.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state      <= IDLE;
      r_grant      <= '0;
      r_owner      <= '0;
      r_last_owner <= idx_t'(NUM_REQ - 1);
      r_burst_cnt  <= '0;
    end else if (w_keep) begin
      r_burst_cnt <= r_burst_cnt + 1'b1;
    end else if (w_found) begin
      r_state      <= OWN;
      r_grant      <= NUM_REQ'(1) << w_pick;
      r_owner      <= w_pick;
      r_last_owner <= w_pick;
      r_burst_cnt  <= '0;
    end else begin
      r_state     <= IDLE;
      r_grant     <= '0;
      r_burst_cnt <= '0;
    end
  end

  always_comb begin
    w_in_data = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (r_grant[i]) begin
        w_in_data = w_in_data | bus.req_data[i*DATA_W +: DATA_W];
      end
    end
  end

  // Tag pipe mirrors the resource latency so the head lines up with res_out_data.
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < RES_LAT; i++) begin
        r_tag[i] <= '0;
      end
    end else begin
      r_tag[0] <= '{valid: w_transfer, index: r_owner};
      for (int i = 1; i < RES_LAT; i++) begin
        r_tag[i] <= r_tag[i-1];
      end
    end
  end

  assign w_head = r_tag[RES_LAT-1];

  assign bus.grant        = r_grant;
  assign bus.res_in_valid = w_transfer && !reset;
  assign bus.res_in_data  = w_in_data;
  assign bus.rsp_valid    = (w_head.valid && !reset) ? (NUM_REQ'(1) << w_head.index) : '0;
  assign bus.rsp_data     = (w_head.valid && !reset) ? bus.res_out_data : '0;

endmodule

// File: tb/tb_resource_arbiter.sv
// Directed and randomized checks of resource_arbiter against a cycle-level reference model.
module tb_resource_arbiter;
  import resource_arb_pkg::*;

  localparam int N     = NUM_REQ_DEF;
  localparam int DW    = DATA_W_DEF;
  localparam int LAT   = RES_LAT_DEF;
  localparam int BURST = MAX_BURST_DEF;
  localparam int WAIT_BOUND = (N - 1) * BURST + 1;

  typedef struct {
    int          due;
    int          idx;
    logic [31:0] operand;
  } exp_t;

  logic clk = 1'b0;
  logic reset;

  resource_arbiter_if #(.NUM_REQ(N), .DATA_W(DW)) bus ();

  resource_arbiter #(
    .NUM_REQ   (N),
    .DATA_W    (DW),
    .RES_LAT   (LAT),
    .MAX_BURST (BURST)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  int nAssert = 0;
  int nFail   = 0;
  int cyc     = 0;

  logic [DW-1:0] reqData [N];
  logic [DW-1:0] resPipe [$];
  exp_t          pending [$];
  int            waitCnt [N];

  // Reference model: who owns the resource and how many transfers it has made this tenure.
  bit mKnown  = 1'b0;
  bit mOwning = 1'b0;
  int mOwner  = 0;
  int mLast   = N - 1;
  int mCount  = 0;

  logic [N-1:0]  obsGrant;
  logic          obsInValid;
  logic [N-1:0]  obsRspValid;
  logic [DW-1:0] obsRspData;

  function automatic logic [DW-1:0] resourceFn(input logic [DW-1:0] x);
    return (x ^ 32'h5A5A_C3C3) + 32'h0000_0101;
  endfunction

  task automatic checkOutput(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    nAssert++;
    assert (obs === exp) else begin
      nFail++;
      $error("[TB] FAIL %s: observed 0x%0h expected 0x%0h (cycle %0d)", tag, obs, exp, cyc);
    end
  endtask

  task automatic applyStimulus(input logic rst, input logic [N-1:0] r);
    logic [N-1:0]  expGrant;
    logic [N-1:0]  expRspV;
    logic [DW-1:0] expRspD;
    logic [DW-1:0] expInData;
    bit            transfer;
    bit            found;
    int            cand;
    @(negedge clk);
    reset   = rst;
    bus.req = r;
    for (int i = 0; i < N; i++) bus.req_data[i*DW +: DW] = reqData[i];
    bus.res_out_data = resourceFn(resPipe[0]);
    #1;
    expGrant  = (mKnown && mOwning) ? (N'(1) << mOwner) : '0;
    expInData = (mKnown && mOwning) ? reqData[mOwner] : '0;
    transfer  = mKnown && mOwning && r[mOwner];
    if (mKnown) begin
      checkOutput("grant", bus.grant, expGrant);
      checkOutput("res_in_data", bus.res_in_data, expInData);
    end
    checkOutput("res_in_valid", bus.res_in_valid, transfer && !rst);
    checkOutput("grant_onehot0", $onehot0(bus.grant), 1'b1);
    expRspV = '0;
    expRspD = '0;
    if (!rst && pending.size() > 0 && pending[0].due == cyc) begin
      expRspV = N'(1) << pending[0].idx;
      expRspD = resourceFn(pending[0].operand);
      void'(pending.pop_front());
    end
    checkOutput("rsp_valid", bus.rsp_valid, expRspV);
    checkOutput("rsp_data", bus.rsp_data, expRspD);
    for (int i = 0; i < N; i++) begin
      if (rst || !r[i] || bus.grant[i]) waitCnt[i] = 0;
      else waitCnt[i]++;
      checkOutput($sformatf("wait_bound_%0d", i), 64'(waitCnt[i] <= WAIT_BOUND), 64'(1));
    end
    obsGrant    = bus.grant;
    obsInValid  = bus.res_in_valid;
    obsRspValid = bus.rsp_valid;
    obsRspData  = bus.rsp_data;
    if (rst) begin
      mKnown  = 1'b1;
      mOwning = 1'b0;
      mLast   = N - 1;
      mCount  = 0;
      pending.delete();
    end else if (mKnown) begin
      if (transfer) pending.push_back('{due: cyc + LAT, idx: mOwner, operand: reqData[mOwner]});
      // Tenure continues only if this cycle's transfer leaves the owner below its burst allowance.
      if (transfer && (mCount + 1) < BURST) begin
        mCount++;
      end else begin
        found = 1'b0;
        for (int k = 1; k <= N; k++) begin
          cand = (mLast + k) % N;
          if (!found && r[cand]) begin
            found  = 1'b1;
            mOwner = cand;
            mLast  = cand;
          end
        end
        mOwning = found;
        mCount  = 0;
      end
    end
    resPipe.push_back(bus.res_in_data);
    void'(resPipe.pop_front());
    cyc++;
  endtask

  task automatic resetDut();
    applyStimulus(1'b1, '0);
    applyStimulus(1'b1, '0);
  endtask

  initial begin
    int issues;
    int returns;
    int grantHold;
    logic [N-1:0] curReq;
    reset = 1'b1;
    bus.req = '0;
    bus.req_data = '0;
    bus.res_out_data = '0;
    for (int i = 0; i < LAT; i++) resPipe.push_back('0);
    for (int i = 0; i < N; i++) begin
      reqData[i] = DW'(32'h11 * (i + 1));
      waitCnt[i] = 0;
    end

    $display("[TB] single requestor, issue and return latency");
    resetDut();
    checkOutput("reset_grant", obsGrant, '0);
    checkOutput("reset_rsp_valid", obsRspValid, '0);
    applyStimulus(1'b0, 4'b0001);
    checkOutput("first_grant_delay", obsGrant, '0);
    applyStimulus(1'b0, 4'b0001);
    checkOutput("grant_req0", obsGrant, 4'b0001);
    applyStimulus(1'b0, 4'b0001);
    applyStimulus(1'b0, 4'b0001);
    checkOutput("rsp_req0_valid", obsRspValid, 4'b0001);
    checkOutput("rsp_req0_data", obsRspData, resourceFn(32'h11));
    for (int k = 0; k < 4; k++) applyStimulus(1'b0, 4'b0001);
    checkOutput("lone_regrant_no_bubble", obsInValid, 1'b1);

    $display("[TB] all requesting, round-robin tenures");
    resetDut();
    for (int k = 0; k < 18; k++) begin
      for (int i = 0; i < N; i++) reqData[i] = $urandom();
      applyStimulus(1'b0, 4'b1111);
      checkOutput($sformatf("rr_seq_%0d", k), obsGrant,
                  (k == 0) ? 4'b0000 : 4'(1 << (((k - 1) / BURST) % N)));
    end

    $display("[TB] lone requestor across burst boundary");
    resetDut();
    issues = 0;
    returns = 0;
    grantHold = 0;
    for (int k = 0; k < 14; k++) begin
      reqData[2] = $urandom();
      applyStimulus(1'b0, (k < 11) ? 4'b0100 : 4'b0000);
      if (k < 11 && obsGrant == 4'b0100) grantHold++;
      if (obsInValid) issues++;
      if (obsRspValid == 4'b0100) returns++;
    end
    checkOutput("lone_grant_cycles", grantHold, 10);
    checkOutput("lone_issues", issues, 10);
    checkOutput("lone_returns", returns, 10);

    $display("[TB] owner drops mid-burst");
    resetDut();
    applyStimulus(1'b0, 4'b1010);
    applyStimulus(1'b0, 4'b1010);
    checkOutput("drop_owner1_grant", obsGrant, 4'b0010);
    applyStimulus(1'b0, 4'b1000);
    checkOutput("drop_bubble_grant", obsGrant, 4'b0010);
    checkOutput("drop_bubble_noissue", obsInValid, 1'b0);
    applyStimulus(1'b0, 4'b1000);
    checkOutput("drop_move_grant", obsGrant, 4'b1000);
    applyStimulus(1'b0, 4'b0000);
    applyStimulus(1'b0, 4'b0000);
    checkOutput("drop_next_rsp_idx3", obsRspValid, 4'b1000);

    $display("[TB] reset with results in flight");
    resetDut();
    applyStimulus(1'b0, 4'b0000);
    for (int k = 1; k <= 6; k++) begin
      applyStimulus(1'b0, 4'b0011);
      if (k == 5) checkOutput("inflight_issue0", obsGrant & {N{obsInValid}}, 4'b0001);
      if (k == 6) checkOutput("inflight_issue1", obsGrant & {N{obsInValid}}, 4'b0010);
    end
    applyStimulus(1'b1, 4'b0011);
    checkOutput("inflight_rsp_c7", obsRspValid, '0);
    applyStimulus(1'b0, 4'b0000);
    checkOutput("inflight_grant_c8", obsGrant, '0);
    checkOutput("inflight_rsp_c8", obsRspValid, '0);
    applyStimulus(1'b0, 4'b0000);
    checkOutput("inflight_rsp_c9", obsRspValid, '0);

    $display("[TB] randomized traffic");
    resetDut();
    curReq = '0;
    for (int k = 0; k < 10000; k++) begin
      for (int i = 0; i < N; i++) begin
        reqData[i] = $urandom();
        if ($urandom_range(0, 7) == 0) curReq[i] = ~curReq[i];
      end
      applyStimulus(($urandom_range(0, 999) == 0), curReq);
    end
    for (int k = 0; k < LAT + 1; k++) applyStimulus(1'b0, '0);
    checkOutput("scoreboard_drained", pending.size(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", nAssert, nFail);
    $finish;
  end

endmodule

// File: doc/resource_arbiter.md
RESOURCE_ARBITER -- requirements
Module: resource_arbiter

Interface
REQ-001 Parameter NUM_REQ, default 4: number of pipeline requestors sharing the resource; SHALL be 2..8.
REQ-002 Parameter DATA_W, default 32: request and result data width.
REQ-003 Parameter RES_LAT, default 2: fixed resource latency in cycles; SHALL be 1..4.
REQ-004 Parameter MAX_BURST, default 4: maximum consecutive transfers per grant tenure.
REQ-005 clk  in  1  single clock; all state SHALL update on the rising edge.
REQ-006 reset  in  1  synchronous, active-high reset.
REQ-007 req  in  NUM_REQ  per-requestor request, taken from each pipeline's arbiter_req.
REQ-008 req_data  in  NUM_REQ*DATA_W  requestor i data at bits [i*DATA_W +: DATA_W], taken from its resource_input.
REQ-009 grant  out  NUM_REQ  registered, one-hot or zero; drives each pipeline's arbiter_grant.
REQ-010 res_in_valid  out  1  issue strobe to the shared resource.
REQ-011 res_in_data  out  DATA_W  operand to the shared resource.
REQ-012 res_out_data  in  DATA_W  resource result, valid exactly RES_LAT cycles after its issue.
REQ-013 rsp_valid  out  NUM_REQ  one-hot result-return strobe per requestor.
REQ-014 rsp_data  out  DATA_W  returned result, common to all requestors.

Function
REQ-015 Transfer: a transfer SHALL occur in cycle t iff grant[i] and req[i] are both high in cycle t.
REQ-016 Issue path:
- res_in_valid SHALL equal |(grant & req).
- res_in_data SHALL be req_data of the granted index, combinationally, with zero input-to-output register latency.
- res_in_data SHALL be 0 when grant is zero.
REQ-017 FSM states: IDLE (grant zero) and OWN (one requestor granted).
REQ-018 Next-grant rule in OWN: if req of the owner is high and burst_cnt < MAX_BURST-1, keep the owner. Otherwise grant the first requestor with req high, searching round-robin from last_owner+1.
REQ-019 Next-grant rule in IDLE: same round-robin search as REQ-018.
REQ-020 If no req is high, the FSM SHALL go to IDLE and grant SHALL be 0 in the next cycle.
REQ-021 A lone requestor at MAX_BURST SHALL be re-granted with no bubble cycle; burst_cnt SHALL restart at 0.
REQ-022 burst_cnt SHALL increment per transfer and clear on an owner change.
REQ-023 A grant cycle with req low (requestor dropped) SHALL issue nothing. The grant SHALL move or drop on the next cycle.
REQ-024 Tag pipeline:
- Depth RES_LAT; each entry holds {valid, index}.
- Each issue SHALL push {1, granted index}; each non-issue cycle SHALL push {0, x}.
REQ-025 Return path:
- rsp_valid[idx] SHALL be high in the cycle the tag-pipe head is valid.
- rsp_data SHALL equal res_out_data in that cycle, else 0.
- Result-to-requestor latency SHALL be exactly RES_LAT cycles after issue.
REQ-026 Back-to-back issues SHALL return back-to-back results in issue order. No result SHALL be dropped or duplicated.
REQ-027 Issue and return in the same cycle for different requestors SHALL both occur.

Reset
REQ-028 On reset, the block SHALL set:
- grant=0, state IDLE, burst_cnt=0
- last_owner=NUM_REQ-1, so requestor 0 wins first
- all tag-pipe valids=0
REQ-029 While reset is high, res_in_valid and rsp_valid SHALL be 0.
REQ-030 Reset mid-operation SHALL discard in-flight tags. No rsp_valid SHALL be produced for them after reset.
REQ-031 The first grant after reset release SHALL appear no earlier than the cycle after req is sampled.

Structure
REQ-032 Package resource_arb_pkg SHALL hold NUM_REQ, DATA_W, RES_LAT and MAX_BURST defaults, the requestor-index type, the tag struct {valid, index} and the FSM state enum.
REQ-033 Round-robin selection SHALL be one combinational sub-module, rr_pick, with inputs req and last_owner and outputs found and index.
REQ-034 All outputs except res_in_valid, res_in_data, rsp_valid and rsp_data SHALL be registered.

Verification
REQ-035 Reset, then req=4'b0001 with data 0x11 held -> grant=0001 from cycle 1. Issue each cycle; rsp_valid=0001 with rsp_data=res_out_data 2 cycles after each issue.
REQ-036 req=4'b1111 continuous -> grant sequence 0001 x4, 0010 x4, 0100 x4, 1000 x4, then 0001. Exactly 4 transfers per tenure.
REQ-037 req=4'b0100 only, held 10 cycles -> grant stays 0100 with no gap at the burst boundary. 10 issues, 10 returns to index 2.
REQ-038 Owner 1 drops req mid-burst while req[3]=1 -> one cycle with grant=0010 and no issue, then grant=1000. The next result is tagged index 3.
REQ-039 Issues to requestors 0 and 1 in cycles 5 and 6, reset in cycle 7 -> no rsp_valid in cycles 7-9, grant=0 in cycle 8.
REQ-040 Random req/data for 10k cycles against a scoreboard:
- every issued operand returns to its issuer in order with exact latency;
- grant is always one-hot or zero;
- no requestor waits longer than (NUM_REQ-1)*MAX_BURST+1 cycles while holding req.
